// File: rtl/alu_pipe.sv
// alu_pipe: start/done ALU on WIDTH-bit operands. Single-cycle ops and a
// MULT_LAT-cycle multiply share one registered result/err/done path.
module alu_pipe #(
  parameter int WIDTH    = 8,
  parameter int MULT_LAT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           op,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2*WIDTH-1:0]   result
);
  typedef enum logic {IDLE, EXEC} state_t;
  localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_AND = 3'b010,
                         OP_XOR = 3'b011, OP_MUL = 3'b100, OP_SUB = 3'b101;
  state_t               r_state, w_state_nx;
  logic [3:0]           r_cnt, w_cnt_nx;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [2:0]           r_op;
  logic                 r_done, r_err;
  logic [2*WIDTH-1:0]   r_result;
  logic                 w_acc, w_fin;
  logic [WIDTH:0]       w_sum, w_diff;
  logic [2*WIDTH-1:0]   w_prod, w_res;
  assign w_acc = (r_state == IDLE) && start;
  assign w_fin = (r_state == EXEC) && (r_cnt == 4'd1);
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (w_acc) begin
      w_state_nx = EXEC;
      w_cnt_nx   = (op == OP_MUL) ? 4'(MULT_LAT) : 4'd1;
    end else if (r_state == EXEC) begin
      w_state_nx = w_fin ? IDLE : EXEC;
      w_cnt_nx   = r_cnt - 4'd1;
    end
  end
  // bit WIDTH of the difference is the borrow, matching the carry of the sum
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};
  assign w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  always_comb begin
    w_res = (r_op == OP_NOP) ? r_result :
            (r_op == OP_ADD) ? {{(WIDTH-1){1'b0}}, w_sum} :
            (r_op == OP_AND) ? {{WIDTH{1'b0}}, r_a & r_b} :
            (r_op == OP_XOR) ? {{WIDTH{1'b0}}, r_a ^ r_b} :
            (r_op == OP_MUL) ? w_prod :
            (r_op == OP_SUB) ? {{(WIDTH-1){1'b0}}, w_diff} : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_done  <= w_fin;
      if (w_acc) begin
        r_a  <= A;
        r_b  <= B;
        r_op <= op;
      end
      if (w_fin) begin
        r_err    <= (r_op[2:1] == 2'b11);
        r_result <= w_res;
      end
    end
  end
  assign busy   = (r_state == EXEC);
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks of alu_pipe at (8,3), (16,5) and (8,1).
module tb_alu_pipe;
  logic        clk = 0, reset = 1;
  logic [15:0] a_in = '0, b_in = '0;
  logic [2:0]  op_in = '0;
  logic [2:0]  st = '0;
  logic        d0_busy, d0_done, d0_err, d1_busy, d1_done, d1_err, d2_busy, d2_done, d2_err;
  logic [15:0] d0_res, d2_res;
  logic [31:0] d1_res;
  int          cur = 0, n_chk = 0, n_err = 0;
  logic        c_busy, c_done, c_err;
  logic [31:0] c_res;
  always #5 clk = ~clk;
  alu_pipe #(.WIDTH(8), .MULT_LAT(3)) u_d0 (.clk(clk), .reset(reset), .A(a_in[7:0]), .B(b_in[7:0]),
    .op(op_in), .start(st[0]), .busy(d0_busy), .done(d0_done), .err(d0_err), .result(d0_res));
  alu_pipe #(.WIDTH(16), .MULT_LAT(5)) u_d1 (.clk(clk), .reset(reset), .A(a_in), .B(b_in),
    .op(op_in), .start(st[1]), .busy(d1_busy), .done(d1_done), .err(d1_err), .result(d1_res));
  alu_pipe #(.WIDTH(8), .MULT_LAT(1)) u_d2 (.clk(clk), .reset(reset), .A(a_in[7:0]), .B(b_in[7:0]),
    .op(op_in), .start(st[2]), .busy(d2_busy), .done(d2_done), .err(d2_err), .result(d2_res));
  always_comb begin
    c_busy = (cur == 0) ? d0_busy : (cur == 1) ? d1_busy : d2_busy;
    c_done = (cur == 0) ? d0_done : (cur == 1) ? d1_done : d2_done;
    c_err  = (cur == 0) ? d0_err  : (cur == 1) ? d1_err  : d2_err;
    c_res  = (cur == 0) ? {16'h0, d0_res} : (cur == 1) ? d1_res : {16'h0, d2_res};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input int d, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] er, input logic ee, input int lat, input string tag);
    int n;
    cur = d;
    op_in = o; a_in = a; b_in = b; st[d] = 1'b1;
    @(posedge clk); #1;
    st[d] = 1'b0;
    a_in = ~a; b_in = ~b; op_in = 3'b111;
    chk({tag, ".busy"}, 32'(c_busy), 32'd1);
    n = 0;
    while (!c_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".lat"}, 32'(n), 32'(lat));
    chk({tag, ".res"}, c_res, er);
    chk({tag, ".err"}, 32'(c_err), 32'(ee));
    chk({tag, ".idle"}, 32'(c_busy), 32'd0);
  endtask
  initial begin
    int n;
    #1;
    chk("rst.busy", 32'(d0_busy), 32'd0);
    chk("rst.done", 32'(d0_done), 32'd0);
    chk("rst.res", 32'(d0_res), 32'd0);
    @(posedge clk); #1;
    reset = 0;
    run(0, 3'b001, 16'hFF, 16'h01, 32'h0100, 1'b0, 1, "add");
    run(0, 3'b101, 16'h00, 16'h01, 32'h01FF, 1'b0, 1, "sub");
    run(0, 3'b011, 16'hF0, 16'h3C, 32'h00CC, 1'b0, 1, "xor");
    // mul with start held high; the add request is ignored until the mul finishes
    cur = 0;
    op_in = 3'b100; a_in = 16'hFF; b_in = 16'hFF; st[0] = 1'b1;
    @(posedge clk); #1;
    op_in = 3'b001; a_in = 16'h1; b_in = 16'h2;
    chk("b2b.e0.busy", 32'(d0_busy), 32'd1);
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #1;
      chk("b2b.mid.busy", 32'(d0_busy), 32'd1);
      chk("b2b.mid.done", 32'(d0_done), 32'd0);
    end
    @(posedge clk); #1;
    chk("b2b.e3.done", 32'(d0_done), 32'd1);
    chk("b2b.e3.res", 32'(d0_res), 32'hFE01);
    chk("b2b.e3.busy", 32'(d0_busy), 32'd0);
    @(posedge clk); #1;
    st[0] = 1'b0;
    chk("b2b.e4.busy", 32'(d0_busy), 32'd1);
    chk("b2b.e4.done", 32'(d0_done), 32'd0);
    chk("b2b.e4.res", 32'(d0_res), 32'hFE01);
    @(posedge clk); #1;
    chk("b2b.e5.done", 32'(d0_done), 32'd1);
    chk("b2b.e5.res", 32'(d0_res), 32'h0003);
    @(posedge clk); #1;
    chk("b2b.pulse", 32'(d0_done), 32'd0);
    run(0, 3'b000, 16'h12, 16'h34, 32'h0003, 1'b0, 1, "nop");
    run(0, 3'b110, 16'h12, 16'h34, 32'h0000, 1'b1, 1, "inv");
    run(0, 3'b010, 16'h0F, 16'hFF, 32'h000F, 1'b0, 1, "and");
    // reset in the middle of a mul: aborted, no done afterwards
    op_in = 3'b100; a_in = 16'h3; b_in = 16'h3; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1;
    #1;
    chk("mrst.busy", 32'(d0_busy), 32'd0);
    chk("mrst.done", 32'(d0_done), 32'd0);
    chk("mrst.err", 32'(d0_err), 32'd0);
    chk("mrst.res", 32'(d0_res), 32'd0);
    #2 reset = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n += int'(d0_done);
    end
    chk("mrst.nodone", 32'(n), 32'd0);
    run(0, 3'b001, 16'h05, 16'h06, 32'h000B, 1'b0, 1, "post");
    run(1, 3'b100, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 5, "w16.mul");
    run(1, 3'b101, 16'h0000, 16'h0001, 32'h0001FFFF, 1'b0, 1, "w16.sub");
    run(1, 3'b001, 16'hFFFF, 16'hFFFF, 32'h0001FFFE, 1'b0, 1, "w16.add");
    run(1, 3'b111, 16'h1234, 16'h5678, 32'h00000000, 1'b1, 1, "w16.inv");
    run(2, 3'b100, 16'h10, 16'h10, 32'h0100, 1'b0, 1, "l1.mul");
    run(2, 3'b100, 16'hFF, 16'hFE, 32'hFD02, 1'b0, 1, "l1.mul2");
    run(2, 3'b011, 16'hAA, 16'h55, 32'h00FF, 1'b0, 1, "l1.xor");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
